// File: rtl/red_pitaya_slew_limit_if.sv
// Bus interface for the slew limiter: the standard lockbox sys bus.
//   sys_addr/sys_wdata/sys_wen/sys_ren : master -> slave request
//   sys_rdata/sys_err/sys_ack          : slave -> master response
interface red_pitaya_slew_limit_if;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    modport master (
        output sys_addr, sys_wdata, sys_wen, sys_ren,
        input  sys_rdata, sys_err, sys_ack
    );

    modport slave (
        input  sys_addr, sys_wdata, sys_wen, sys_ren,
        output sys_rdata, sys_err, sys_ack
    );
endinterface

// File: rtl/red_pitaya_slew_limit.sv
// Per-channel output slew-rate limiter sitting between the limit stage and
// the DAC. Each channel's output may change by at most STEP per cycle; on
// disable the output ramps softly back to zero.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   dat_a_i, dat_b_i      signed channel inputs from the limit stage
//   dat_a_o, dat_b_o      signed slew-limited outputs to the DAC
//   slewing_o             [0]=A, [1]=B: channel in SLEW or RAMP_DOWN
//   sys                   sys bus slave (CFG, STEP_A, STEP_B, STAT)
//
// Channel FSM states:
//   state        | meaning
//   OFF          | output held at 0, waiting for enable
//   TRACK        | output follows target with one cycle latency
//   SLEW         | output moving toward target by STEP per cycle
//   RAMP_DOWN    | disabled, output moving toward 0 by STEP per cycle
module red_pitaya_slew_limit #(
    parameter int DW   = 14,
    parameter int CNTW = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic signed [DW-1:0] dat_a_i,
    input  logic signed [DW-1:0] dat_b_i,
    output logic signed [DW-1:0] dat_a_o,
    output logic signed [DW-1:0] dat_b_o,
    output logic [1:0]           slewing_o,
    red_pitaya_slew_limit_if.slave sys
);
    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_TRACK     = 2'd1,
        ST_SLEW      = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

    typedef struct packed {
        state_t        st;
        logic [DW-1:0] out;
    } chan_t;

    localparam logic [7:0] A_CFG    = 8'h00;
    localparam logic [7:0] A_STEP_A = 8'h04;
    localparam logic [7:0] A_STEP_B = 8'h08;
    localparam logic [7:0] A_STAT   = 8'h0C;

    // Next output/state for one channel. The target is 0 while disabled, so
    // the same |diff| vs step test drives both slewing and ramping down.
    // When |diff| > step the moved value lies strictly between out and the
    // target, so it always fits in DW bits and cannot overshoot.
    function automatic chan_t chan_next(input logic          en,
                                        input logic [DW-1:0] din,
                                        input logic [DW-1:0] out,
                                        input state_t        st,
                                        input logic [12:0]   step);
        logic signed [DW:0] tgt;
        logic signed [DW:0] diff;
        logic [DW:0]        mag;
        logic [DW-1:0]      step_dw;
        logic [DW-1:0]      moved;
        logic               fits;
        chan_t              n;
        tgt     = en ? $signed({din[DW-1], din}) : '0;
        diff    = tgt - $signed({out[DW-1], out});
        mag     = diff[DW] ? $unsigned(-diff) : $unsigned(diff);
        step_dw = {{(DW-13){1'b0}}, step};
        fits    = (mag <= {{(DW-12){1'b0}}, step});
        moved   = diff[DW] ? (out - step_dw) : (out + step_dw);
        n.st    = st;
        n.out   = out;
        if (step == '0) begin
            n.out = tgt[DW-1:0];
            n.st  = en ? ST_TRACK : ST_OFF;
        end else if (st == ST_OFF) begin
            n.out = '0;
            n.st  = en ? ST_SLEW : ST_OFF;
        end else begin
            n.out = fits ? tgt[DW-1:0] : moved;
            if (en) n.st = fits ? ST_TRACK : ST_SLEW;
            else    n.st = fits ? ST_OFF : ST_RAMP_DOWN;
        end
        return n;
    endfunction

    logic [1:0]      en_q, en_d;
    logic [12:0]     step_a_q, step_a_d;
    logic [12:0]     step_b_q, step_b_d;
    logic            ack_q, ack_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [CNTW-1:0] cnt_a_q, cnt_a_d;
    logic [CNTW-1:0] cnt_b_q, cnt_b_d;
    logic [DW-1:0]   out_a_q, out_a_d;
    logic [DW-1:0]   out_b_q, out_b_d;
    state_t          state_a_q, state_a_d;
    state_t          state_b_q, state_b_d;
    chan_t           nxt_a, nxt_b;
    logic [7:0]      addr;
    logic            stat_clr;
    logic            slew_a, slew_b;
    logic            unused_bus;

    assign addr       = sys.sys_addr[7:0];
    assign stat_clr   = sys.sys_wen && (addr == A_STAT);
    assign unused_bus = ^{sys.sys_addr[31:8], sys.sys_wdata[31:13]};

    // Bus register file; ack and read data are registered together.
    always_comb begin
        en_d     = en_q;
        step_a_d = step_a_q;
        step_b_d = step_b_q;
        rdata_d  = rdata_q;
        ack_d    = sys.sys_wen | sys.sys_ren;
        if (sys.sys_wen) begin
            case (addr)
                A_CFG:    en_d     = sys.sys_wdata[1:0];
                A_STEP_A: step_a_d = sys.sys_wdata[12:0];
                A_STEP_B: step_b_d = sys.sys_wdata[12:0];
                default:  ;
            endcase
        end
        if (sys.sys_ren) begin
            case (addr)
                A_CFG:    rdata_d = {30'd0, en_q};
                A_STEP_A: rdata_d = {19'd0, step_a_q};
                A_STEP_B: rdata_d = {19'd0, step_b_q};
                A_STAT:   rdata_d = 32'(cnt_a_q) | (32'(cnt_b_q) << 16);
                default:  rdata_d = '0;
            endcase
        end
    end

    assign slew_a = (state_a_q == ST_SLEW) || (state_a_q == ST_RAMP_DOWN);
    assign slew_b = (state_b_q == ST_SLEW) || (state_b_q == ST_RAMP_DOWN);

    always_comb begin
        nxt_a     = chan_next(en_q[0], dat_a_i, out_a_q, state_a_q, step_a_q);
        nxt_b     = chan_next(en_q[1], dat_b_i, out_b_q, state_b_q, step_b_q);
        out_a_d   = nxt_a.out;
        state_a_d = nxt_a.st;
        out_b_d   = nxt_b.out;
        state_b_d = nxt_b.st;
        // A STAT write wins over a same-cycle increment.
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (stat_clr) begin
            cnt_a_d = '0;
            cnt_b_d = '0;
        end else begin
            if (slew_a && (cnt_a_q != '1)) cnt_a_d = cnt_a_q + 1'b1;
            if (slew_b && (cnt_b_q != '1)) cnt_b_d = cnt_b_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q      <= '0;
            step_a_q  <= '0;
            step_b_q  <= '0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            out_a_q   <= '0;
            out_b_q   <= '0;
            state_a_q <= ST_OFF;
            state_b_q <= ST_OFF;
        end else begin
            en_q      <= en_d;
            step_a_q  <= step_a_d;
            step_b_q  <= step_b_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
            out_a_q   <= out_a_d;
            out_b_q   <= out_b_d;
            state_a_q <= state_a_d;
            state_b_q <= state_b_d;
        end
    end

    assign dat_a_o       = out_a_q;
    assign dat_b_o       = out_b_q;
    assign slewing_o     = {slew_b, slew_a};
    assign sys.sys_rdata = rdata_q;
    assign sys.sys_ack   = ack_q;
    assign sys.sys_err   = 1'b0;
endmodule
